// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, instruction field positions, opcodes and the ID/EX bundle.
// Used by the decode stage and reused by the EX stage.
package cpu_pkg;

  localparam int PC_WIDTH   = 8;
  localparam int DATA_WIDTH = 16;
  localparam int REG_ADDR_W = 4;
  localparam int INSTR_W    = 16;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_BEQZ = 4'h9;

  typedef struct packed {
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic                  reg_we;
    logic                  mem_rd;
    logic                  mem_wr;
    logic                  illegal;
    logic [DATA_WIDTH-1:0] imm;
  } dec_ctl_t;

  typedef struct packed {
    logic                  valid;
    logic [3:0]            opcode;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] imm;
    logic [PC_WIDTH-1:0]   pc;
    logic                  reg_we;
    logic                  mem_rd;
    logic                  mem_wr;
    logic                  illegal;
  } id_ex_t;

endpackage

// File: rtl/decode_stage_if.sv
// Signal bundle between the decode stage and its neighbours (fetch, reg_file, writeback, EX).
// master = surrounding pipeline, slave = decode stage.
interface decode_stage_if
  import cpu_pkg::*;
#(
  parameter int PC_W   = PC_WIDTH,
  parameter int DATA_W = DATA_WIDTH,
  parameter int REG_AW = REG_ADDR_W
);
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic               id_stall;

  logic [REG_AW-1:0]  rf_read_reg1;
  logic [REG_AW-1:0]  rf_read_reg2;
  logic [DATA_W-1:0]  rf_read_data1;
  logic [DATA_W-1:0]  rf_read_data2;

  logic               wb_we;
  logic [REG_AW-1:0]  wb_reg;
  logic [DATA_W-1:0]  wb_data;

  logic               ex_ready;
  logic               ex_flush;
  logic               ex_valid;
  logic [3:0]         ex_opcode;
  logic [REG_AW-1:0]  ex_rd;
  logic [DATA_W-1:0]  ex_op_a;
  logic [DATA_W-1:0]  ex_op_b;
  logic [DATA_W-1:0]  ex_imm;
  logic [PC_W-1:0]    ex_pc;
  logic               ex_reg_we;
  logic               ex_mem_rd;
  logic               ex_mem_wr;
  logic               ex_illegal;

  modport master (
    output if_valid, if_instr, if_pc, rf_read_data1, rf_read_data2,
           wb_we, wb_reg, wb_data, ex_ready, ex_flush,
    input  id_stall, rf_read_reg1, rf_read_reg2, ex_valid, ex_opcode, ex_rd,
           ex_op_a, ex_op_b, ex_imm, ex_pc, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_illegal
  );

  modport slave (
    input  if_valid, if_instr, if_pc, rf_read_data1, rf_read_data2,
           wb_we, wb_reg, wb_data, ex_ready, ex_flush,
    output id_stall, rf_read_reg1, rf_read_reg2, ex_valid, ex_opcode, ex_rd,
           ex_op_a, ex_op_b, ex_imm, ex_pc, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_illegal
  );
endinterface

// File: rtl/decode_stage_instr_decoder.sv
// Combinational opcode decode: source usage, control bits and sign-extended immediate.
// Zero latency, no state.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] op,
  input  logic [7:0] imm_field,
  output dec_ctl_t   ctl
);

  always_comb begin
    ctl = '0;
    case (op)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        ctl.uses_rs1 = 1'b1;
        ctl.uses_rs2 = 1'b1;
        ctl.reg_we   = 1'b1;
      end
      OP_LDI: begin
        ctl.reg_we = 1'b1;
        ctl.imm    = {{(DATA_WIDTH-8){imm_field[7]}}, imm_field};
      end
      OP_LD: begin
        ctl.uses_rs1 = 1'b1;
        ctl.reg_we   = 1'b1;
        ctl.mem_rd   = 1'b1;
      end
      OP_ST: begin
        ctl.uses_rs1 = 1'b1;
        ctl.uses_rs2 = 1'b1;
        ctl.mem_wr   = 1'b1;
      end
      OP_BEQZ: begin
        ctl.uses_rs1 = 1'b1;
        ctl.imm      = {{(DATA_WIDTH-4){imm_field[3]}}, imm_field[3:0]};
      end
      default: ctl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// ID stage: decode, writeback bypass, load-use hazard detection, ID/EX register; 1-cycle latency.
// Stalls fetch on a load-use hazard or when EX is not ready; a flush overrides both.
module decode_stage
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  bus
);

  logic [3:0]            op;
  logic [REG_ADDR_W-1:0] rd;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  dec_ctl_t              ctl;
  id_ex_t                ex_q;
  id_ex_t                dec_d;
  logic                  hazard;

  assign op  = bus.if_instr[OP_MSB:OP_LSB];
  assign rd  = bus.if_instr[RD_MSB:RD_LSB];
  assign rs1 = bus.if_instr[RS1_MSB:RS1_LSB];
  assign rs2 = bus.if_instr[RS2_MSB:RS2_LSB];

  instr_decoder u_dec (
    .op        (op),
    .imm_field (bus.if_instr[7:0]),
    .ctl       (ctl)
  );

  assign bus.rf_read_reg1 = rs1;
  assign bus.rf_read_reg2 = rs2;

  // A load in EX cannot forward its data yet, so a dependent consumer must wait one cycle.
  assign hazard = bus.if_valid && ex_q.valid && ex_q.mem_rd &&
                  ((ctl.uses_rs1 && ex_q.rd == rs1) || (ctl.uses_rs2 && ex_q.rd == rs2));

  assign bus.id_stall = (hazard || !bus.ex_ready) && !bus.ex_flush;

  always_comb begin
    dec_d         = '0;
    dec_d.valid   = bus.if_valid;
    dec_d.opcode  = op;
    dec_d.rd      = rd;
    dec_d.op_a    = (bus.wb_we && bus.wb_reg == rs1) ? bus.wb_data : bus.rf_read_data1;
    dec_d.op_b    = (bus.wb_we && bus.wb_reg == rs2) ? bus.wb_data : bus.rf_read_data2;
    dec_d.imm     = ctl.imm;
    dec_d.pc      = bus.if_pc;
    dec_d.reg_we  = bus.if_valid && ctl.reg_we;
    dec_d.mem_rd  = bus.if_valid && ctl.mem_rd;
    dec_d.mem_wr  = bus.if_valid && ctl.mem_wr;
    dec_d.illegal = bus.if_valid && ctl.illegal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else if (bus.ex_flush) begin
      ex_q <= '0;
    end else if (!bus.ex_ready) begin
      ex_q <= ex_q;
    end else if (hazard) begin
      ex_q.valid  <= 1'b0;
      ex_q.reg_we <= 1'b0;
      ex_q.mem_rd <= 1'b0;
      ex_q.mem_wr <= 1'b0;
    end else begin
      ex_q <= dec_d;
    end
  end

  assign bus.ex_valid   = ex_q.valid;
  assign bus.ex_opcode  = ex_q.opcode;
  assign bus.ex_rd      = ex_q.rd;
  assign bus.ex_op_a    = ex_q.op_a;
  assign bus.ex_op_b    = ex_q.op_b;
  assign bus.ex_imm     = ex_q.imm;
  assign bus.ex_pc      = ex_q.pc;
  assign bus.ex_reg_we  = ex_q.reg_we;
  assign bus.ex_mem_rd  = ex_q.mem_rd;
  assign bus.ex_mem_wr  = ex_q.mem_wr;
  assign bus.ex_illegal = ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios followed by randomized traffic,
// all compared against a behavioural model of the ID stage and an emulated register file.
module tb_decode_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_if bus ();

  decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] regs [16];
  assign bus.rf_read_data1 = regs[bus.rf_read_reg1];
  assign bus.rf_read_data2 = regs[bus.rf_read_reg2];

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model of the ID/EX register contents.
  logic        m_valid, m_we, m_mrd, m_mwr, m_ill;
  logic [3:0]  m_op, m_rd;
  logic [15:0] m_a, m_b, m_imm;
  logic [7:0]  m_pc;
  logic        m_stall;
  logic        last_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // {uses_rs1, uses_rs2, writes_rd, load, store, illegal}
  function automatic logic [5:0] props(input logic [3:0] op);
    case (op)
      4'h0:                         return 6'b000000;
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: return 6'b111000;
      4'h6:                         return 6'b001000;
      4'h7:                         return 6'b101100;
      4'h8:                         return 6'b110010;
      4'h9:                         return 6'b100000;
      default:                      return 6'b000001;
    endcase
  endfunction

  task automatic model_clear();
    m_valid = 0; m_we = 0; m_mrd = 0; m_mwr = 0; m_ill = 0;
    m_op = 0; m_rd = 0; m_a = 0; m_b = 0; m_imm = 0; m_pc = 0;
    m_stall = 0;
  endtask

  task automatic check_ex();
    check("ex_valid",   bus.ex_valid,   m_valid);
    check("ex_reg_we",  bus.ex_reg_we,  m_we);
    check("ex_mem_rd",  bus.ex_mem_rd,  m_mrd);
    check("ex_mem_wr",  bus.ex_mem_wr,  m_mwr);
    check("ex_illegal", bus.ex_illegal, m_ill);
    if (m_valid) begin
      check("ex_opcode", bus.ex_opcode, m_op);
      check("ex_rd",     bus.ex_rd,     m_rd);
      check("ex_op_a",   bus.ex_op_a,   m_a);
      check("ex_op_b",   bus.ex_op_b,   m_b);
      check("ex_imm",    bus.ex_imm,    m_imm);
      check("ex_pc",     bus.ex_pc,     m_pc);
    end
  endtask

  task automatic cycle(input logic v, input logic [15:0] instr, input logic [7:0] pc,
                       input logic we, input logic [3:0] wreg, input logic [15:0] wdat,
                       input logic rdy, input logic fl);
    logic [5:0]  p;
    logic [3:0]  op, rd, rs1, rs2;
    logic [15:0] a, b, imm;
    logic        hz;
    @(negedge clk);
    bus.if_valid = v;  bus.if_instr = instr; bus.if_pc = pc;
    bus.wb_we = we;    bus.wb_reg = wreg;    bus.wb_data = wdat;
    bus.ex_ready = rdy; bus.ex_flush = fl;
    #1;
    op  = instr[15:12]; rd = instr[11:8]; rs1 = instr[7:4]; rs2 = instr[3:0];
    p   = props(op);
    hz  = v && m_valid && m_mrd && ((p[5] && m_rd == rs1) || (p[4] && m_rd == rs2));
    m_stall    = (hz || !rdy) && !fl;
    last_stall = bus.id_stall;
    check("id_stall",     bus.id_stall,     m_stall);
    check("rf_read_reg1", bus.rf_read_reg1, rs1);
    check("rf_read_reg2", bus.rf_read_reg2, rs2);
    a   = (we && wreg == rs1) ? wdat : regs[rs1];
    b   = (we && wreg == rs2) ? wdat : regs[rs2];
    imm = (op == 4'h6) ? 16'($signed(instr[7:0])) :
          (op == 4'h9) ? 16'($signed(instr[3:0])) : 16'h0;
    @(posedge clk);
    if (fl) begin
      model_clear();
    end else if (!rdy) begin
      // registered contents unchanged
    end else if (hz) begin
      m_valid = 0; m_we = 0; m_mrd = 0; m_mwr = 0;
    end else begin
      m_valid = v; m_op = op; m_rd = rd; m_a = a; m_b = b; m_imm = imm; m_pc = pc;
      m_we = v & p[3]; m_mrd = v & p[2]; m_mwr = v & p[1]; m_ill = v & p[0];
    end
    #1;
    if (we) regs[wreg] = wdat;
    check_ex();
  endtask

  initial begin
    logic        v, we, rdy, fl;
    logic [15:0] instr, wdat;
    logic [7:0]  pc;
    logic [3:0]  wreg;

    rst = 1'b1;
    bus.if_valid = 0; bus.if_instr = 0; bus.if_pc = 0;
    bus.wb_we = 0; bus.wb_reg = 0; bus.wb_data = 0;
    bus.ex_ready = 1; bus.ex_flush = 0;
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    regs[1] = 16'd5;
    regs[2] = 16'd7;
    model_clear();
    #12;
    check("reset_ex_valid", bus.ex_valid, 1'b0);
    check("reset_id_stall", bus.id_stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // ADD r3, r1, r2
    cycle(1, 16'h1312, 8'h10, 0, 0, 0, 1, 0);
    check("add_valid", bus.ex_valid, 1'b1);
    check("add_op_a",  bus.ex_op_a,  16'd5);
    check("add_op_b",  bus.ex_op_b,  16'd7);
    check("add_rd",    bus.ex_rd,    4'd3);
    check("add_we",    bus.ex_reg_we, 1'b1);

    // LDI r4, -2
    cycle(1, 16'h64FE, 8'h11, 0, 0, 0, 1, 0);
    check("ldi_imm", bus.ex_imm,    16'hFFFE);
    check("ldi_we",  bus.ex_reg_we, 1'b1);

    // ADD r5, r1, r2 while r1 is written back in the same cycle
    cycle(1, 16'h1512, 8'h12, 1, 4'd1, 16'hABCD, 1, 0);
    check("bypass_op_a", bus.ex_op_a, 16'hABCD);
    check("bypass_op_b", bus.ex_op_b, 16'd7);

    // LD r2,(r1) then ADD r4,r2,r3: one bubble
    cycle(1, 16'h7210, 8'h13, 0, 0, 0, 1, 0);
    cycle(1, 16'h1423, 8'h14, 0, 0, 0, 1, 0);
    check("lu_stall",  last_stall,   1'b1);
    check("lu_bubble", bus.ex_valid, 1'b0);
    cycle(1, 16'h1423, 8'h14, 0, 0, 0, 1, 0);
    check("lu_stall_clear", last_stall,   1'b0);
    check("lu_issue_valid", bus.ex_valid, 1'b1);
    check("lu_issue_rd",    bus.ex_rd,    4'd4);

    // EX backpressure for 3 cycles, then flush while still not ready
    cycle(1, 16'h1312, 8'h15, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 16'h2456, 8'h16, 0, 0, 0, 0, 0);
      check("hold_stall", last_stall, 1'b1);
      check("hold_rd",    bus.ex_rd,  4'd3);
      check("hold_pc",    bus.ex_pc,  8'h15);
    end
    cycle(1, 16'h2456, 8'h16, 0, 0, 0, 0, 1);
    check("flush_stall", last_stall,   1'b0);
    check("flush_valid", bus.ex_valid, 1'b0);

    // Undefined opcode
    cycle(1, 16'hC123, 8'h17, 0, 0, 0, 1, 0);
    check("ill_flag",  bus.ex_illegal, 1'b1);
    check("ill_valid", bus.ex_valid,   1'b1);
    check("ill_we",    bus.ex_reg_we,  1'b0);
    check("ill_mrd",   bus.ex_mem_rd,  1'b0);
    check("ill_mwr",   bus.ex_mem_wr,  1'b0);

    // Asynchronous reset between clock edges
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid",   bus.ex_valid,   1'b0);
    check("arst_illegal", bus.ex_illegal, 1'b0);
    check("arst_pc",      bus.ex_pc,      8'h0);
    check("arst_opcode",  bus.ex_opcode,  4'h0);
    check("arst_stall",   bus.id_stall,   1'b0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic; fetch holds its instruction while a stall is expected
    v = 0; instr = 0; pc = 0;
    for (int n = 0; n < 600; n++) begin
      if (!m_stall) begin
        v     = ($urandom_range(0, 3) != 0);
        instr = 16'($urandom);
        if ($urandom_range(0, 3) == 0) instr[15:12] = 4'h7;
        if (m_valid && $urandom_range(0, 1) == 0) instr[7:4] = m_rd;
        if (m_valid && $urandom_range(0, 2) == 0) instr[3:0] = m_rd;
        pc = 8'($urandom);
      end
      we   = ($urandom_range(0, 1) == 0);
      wreg = ($urandom_range(0, 2) == 0) ? instr[7:4] : 4'($urandom);
      wdat = 16'($urandom);
      rdy  = ($urandom_range(0, 4) != 0);
      fl   = ($urandom_range(0, 11) == 0);
      cycle(v, instr, pc, we, wreg, wdat, rdy, fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the 3-stage pipeline (IF -> ID -> EX/WB).
- Decodes the 16-bit instruction from fetch and drives the two reg_file read addresses.
- Bypasses the same-cycle writeback value, detects load-use hazards and stalls fetch.
- Registers the decoded bundle into the ID/EX pipeline register, with hold and flush support.

Parameters:
PC_W, 8, program counter width
DATA_W, 16, datapath/register width (must match reg_file)
REG_AW, 4, register address width (16 registers)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
if_valid  input  1  fetch presents a valid instruction
if_instr  input  16  instruction word
if_pc  input  PC_W  PC of if_instr
id_stall  output  1  combinational; fetch must hold if_instr/if_pc when high
rf_read_reg1  output  REG_AW  combinational, = if_instr[7:4]
rf_read_reg2  output  REG_AW  combinational, = if_instr[3:0]
rf_read_data1  input  DATA_W  async read data for port 1
rf_read_data2  input  DATA_W  async read data for port 2
wb_we  input  1  writeback write enable (same signals drive reg_file write port)
wb_reg  input  REG_AW  writeback destination
wb_data  input  DATA_W  writeback data
ex_ready  input  1  EX accepts the ID/EX register this cycle
ex_flush  input  1  EX resolved a taken branch; kill the instruction in ID
ex_valid  output  1  ID/EX register holds a live instruction
ex_opcode  output  4  decoded opcode
ex_rd  output  REG_AW  destination register
ex_op_a  output  DATA_W  source operand A (rs1 value)
ex_op_b  output  DATA_W  source operand B (rs2 value)
ex_imm  output  DATA_W  sign-extended immediate
ex_pc  output  PC_W  PC of the instruction
ex_reg_we  output  1  instruction writes ex_rd
ex_mem_rd  output  1  load
ex_mem_wr  output  1  store
ex_illegal  output  1  undefined opcode seen

Behaviour:
- Format: op=[15:12], rd=[11:8], rs1=[7:4], rs2=[3:0].
- Opcodes: 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR; 6 LDI; 7 LD; 8 ST; 9 BEQZ; A-F illegal.
- Immediates: LDI imm = sext(instr[7:0]); BEQZ imm = sext(instr[3:0]); all other opcodes imm = 0.
- Source usage: ALU ops use rs1+rs2; LD and BEQZ use rs1; ST uses rs1 (address) and rs2 (data); NOP, LDI and illegal use none.
- Register writes: ex_reg_we=1 for ALU ops, LDI and LD only.
- Illegal opcodes: decode as NOP (no writes, no memory access) with ex_illegal=1; ex_valid follows normal rules.
- Writeback bypass:
  - op_a = (wb_we && wb_reg==rs1) ? wb_data : rf_read_data1.
  - op_b is the same with rs2 and rf_read_data2.
  - Applies to all 16 registers; r0 is not special.
- Load-use hazard, combinational: hazard = if_valid && ex_valid && ex_mem_rd && ex_rd equals a source the current opcode uses.
- id_stall = (hazard || !ex_ready) && !ex_flush.
- ID/EX register update, first matching rule wins each rising clk:
  1. rst (asynchronous): all ex_* outputs = 0.
  2. ex_flush: ex_valid<=0; the instruction in ID is dropped; other fields don't-care (clear them to 0).
  3. !ex_ready: hold every ex_* field unchanged.
  4. hazard: insert bubble, ex_valid<=0 and ex_reg_we/ex_mem_rd/ex_mem_wr<=0; if_instr is held by fetch and re-decoded next cycle.
  5. Otherwise: load the decoded fields, with ex_valid<=if_valid.
- When if_valid=0, the control bits written are 0.
- Latency: 1 cycle from instruction accepted to ex_valid, with no hazard.
- A load-use stall costs exactly 1 bubble: after the bubble, ex_mem_rd=0, so hazard clears.
- Reset mid-stall: all outputs 0 at once; id_stall is 0 after reset unless ex_ready=0.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (OP_NOP ... OP_BEQZ);
  - field position constants;
  - an id_ex bundle typedef (valid, opcode, rd, op_a, op_b, imm, pc, control bits), reused by the EX stage.
- One sub-module, instr_decoder: purely combinational opcode -> {uses_rs1, uses_rs2, reg_we, mem_rd, mem_wr, illegal, imm}.
- Hazard, bypass and the pipeline register stay in decode_stage.

Test Plan:
- Reset asserted mid-stream with ex_valid=1 -> all ex_* = 0 immediately, before any clock edge; id_stall=0.
- Decode: if_instr=0x1312 (ADD r3,r1,r2), r1=5, r2=7, ex_ready=1 -> next cycle ex_valid=1, ex_op_a=5, ex_op_b=7, ex_rd=3, ex_reg_we=1.
- LDI and bypass:
  - if_instr=0x64FE -> ex_imm=0xFFFE, ex_reg_we=1.
  - Same cycle as an ADD reading r1, with wb_we=1, wb_reg=1, wb_data=0xABCD -> ex_op_a=0xABCD, not the stale reg_file value.
- Load-use: LD r2,(r1) followed by ADD r4,r2,r3 -> id_stall=1 for 1 cycle, one bubble (ex_valid=0), then the ADD issues with ex_valid=1.
- Hold and flush:
  - ex_ready=0 for 3 cycles -> ex_* unchanged and id_stall=1.
  - ex_flush=1 together with ex_ready=0 -> ex_valid=0 next cycle, id_stall=0.
- Illegal: if_instr=0xC123 -> ex_illegal=1, ex_valid=1, ex_reg_we=0, ex_mem_rd=0, ex_mem_wr=0.
